// File: rtl/game_state_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : game_state_ctrl
//  Brief   : Maze-game flow controller: lives, levels, timed phases,
//            frightened mode and a saturating BCD score.
//  Revision: 1.0  initial release
// ============================================================================
module game_state_ctrl #(
    parameter int NUM_GHOSTS    = 4,
    parameter int NUM_DIGITS    = 5,
    parameter int START_LIVES   = 3,
    parameter int MAX_LEVEL     = 4,
    parameter int READY_FRAMES  = 120,
    parameter int DEATH_FRAMES  = 90,
    parameter int CLEAR_FRAMES  = 90,
    parameter int FRIGHT_FRAMES = 360
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    frame_clk,
    input  logic                    start,
    input  logic [NUM_GHOSTS-1:0]   ghost_hit,
    input  logic                    pellet_eaten,
    input  logic                    power_eaten,
    input  logic                    maze_cleared,
    output logic [2:0]              state,
    output logic                    run_en,
    output logic                    frightened,
    output logic                    respawn,
    output logic                    pellet_reload,
    output logic [2:0]              lives,
    output logic [3:0]              level,
    output logic [4*NUM_DIGITS-1:0] score_bcd,
    output logic                    lose_game,
    output logic                    win_game
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_ready = 3'd1;
    localparam logic [2:0] c_st_play  = 3'd2;
    localparam logic [2:0] c_st_dying = 3'd3;
    localparam logic [2:0] c_st_clear = 3'd4;
    localparam logic [2:0] c_st_over  = 3'd5;
    localparam logic [2:0] c_st_win   = 3'd6;

    localparam int c_frames_a   = (READY_FRAMES > DEATH_FRAMES) ? READY_FRAMES : DEATH_FRAMES;
    localparam int c_frames_max = (c_frames_a > CLEAR_FRAMES) ? c_frames_a : CLEAR_FRAMES;
    localparam int c_fw         = $clog2(c_frames_max + 1);
    localparam int c_rw         = $clog2(FRIGHT_FRAMES + 1);
    localparam int c_sw         = 4 * NUM_DIGITS;

    localparam logic [c_fw-1:0] c_ready_ld  = c_fw'(READY_FRAMES);
    localparam logic [c_fw-1:0] c_death_ld  = c_fw'(DEATH_FRAMES);
    localparam logic [c_fw-1:0] c_clear_ld  = c_fw'(CLEAR_FRAMES);
    localparam logic [c_fw-1:0] c_frame_one = c_fw'(1);
    localparam logic [c_rw-1:0] c_fright_ld = c_rw'(FRIGHT_FRAMES);
    localparam logic [c_rw-1:0] c_fcnt_one  = c_rw'(1);
    localparam logic [2:0]      c_lives_ld  = 3'(START_LIVES);
    localparam logic [3:0]      c_max_level = 4'(MAX_LEVEL);
    localparam logic [c_sw-1:0] c_score_sat = {NUM_DIGITS{4'h9}};

    logic [2:0]      r_state;
    logic [c_fw-1:0] r_frames;
    logic            r_fright;
    logic [c_rw-1:0] r_fcnt;
    logic [2:0]      r_lives;
    logic [3:0]      r_level;
    logic [c_sw-1:0] r_score;
    logic            r_respawn;
    logic            r_reload;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_sync3;
    logic            r_start_prev;

    logic            w_tick;
    logic            w_start_rise;
    logic            w_hit_any;
    logic            w_in_play;
    logic            w_frame_done;
    logic [2:0]      w_next;
    logic            w_respawn_nx;
    logic            w_reload_nx;
    logic            w_reinit;
    logic [2:0]      w_lives_nx;
    logic [3:0]      w_level_nx;
    logic [c_fw-1:0] w_frames_ld;
    logic [3:0]      w_tens;
    logic [3:0]      w_hund;
    logic [3:0]      w_add_digit;
    logic [4:0]      w_dsum;
    logic            w_carry;
    logic [c_sw-1:0] w_score_sum;
    logic [c_sw-1:0] w_score_nx;

    assign w_tick       = r_sync2 & ~r_sync3;
    assign w_start_rise = start & ~r_start_prev;
    assign w_hit_any    = |ghost_hit;
    assign w_in_play    = (r_state == c_st_play);
    assign w_frame_done = w_tick && (r_frames == c_frame_one);

    // Tracks start even through reset, so a key held across reset release never counts as a press.
    always_ff @(posedge Clk) begin
        r_start_prev <= start;
    end

    always_comb begin
        w_next       = r_state;
        w_respawn_nx = 1'b0;
        w_reload_nx  = 1'b0;
        w_reinit     = 1'b0;
        w_lives_nx   = r_lives;
        w_level_nx   = r_level;
        case (r_state)
            c_st_idle, c_st_over, c_st_win: begin
                if (w_start_rise) begin
                    w_next       = c_st_ready;
                    w_respawn_nx = 1'b1;
                    w_reload_nx  = 1'b1;
                    w_reinit     = 1'b1;
                    w_lives_nx   = c_lives_ld;
                    w_level_nx   = 4'd1;
                end
            end
            c_st_ready: begin
                if (w_frame_done) w_next = c_st_play;
            end
            c_st_play: begin
                if (w_hit_any && !r_fright) w_next = c_st_dying;
                else if (maze_cleared)      w_next = c_st_clear;
            end
            c_st_dying: begin
                if (w_frame_done) begin
                    if (r_lives == 3'd1) begin
                        w_next     = c_st_over;
                        w_lives_nx = 3'd0;
                    end else begin
                        w_next       = c_st_ready;
                        w_lives_nx   = r_lives - 3'd1;
                        w_respawn_nx = 1'b1;
                    end
                end
            end
            c_st_clear: begin
                if (w_frame_done) begin
                    if (r_level == c_max_level) begin
                        w_next = c_st_win;
                    end else begin
                        w_next       = c_st_ready;
                        w_level_nx   = r_level + 4'd1;
                        w_respawn_nx = 1'b1;
                        w_reload_nx  = 1'b1;
                    end
                end
            end
            default: w_next = c_st_idle;
        endcase
    end

    always_comb begin
        case (w_next)
            c_st_ready: w_frames_ld = c_ready_ld;
            c_st_dying: w_frames_ld = c_death_ld;
            c_st_clear: w_frames_ld = c_clear_ld;
            default:    w_frames_ld = '0;
        endcase
    end

    // Event points expressed as BCD digits: tens = pellet(1)+power(5), hundreds = fright hit(2).
    assign w_tens = {3'd0, pellet_eaten} + (power_eaten ? 4'd5 : 4'd0);
    assign w_hund = (w_hit_any && r_fright) ? 4'd2 : 4'd0;

    always_comb begin
        w_carry     = 1'b0;
        w_score_sum = '0;
        w_dsum      = '0;
        w_add_digit = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (d == 1)      w_add_digit = w_tens;
            else if (d == 2) w_add_digit = w_hund;
            else             w_add_digit = 4'd0;
            w_dsum  = {1'b0, r_score[4*d +: 4]} + {1'b0, w_add_digit} + {4'd0, w_carry};
            w_carry = (w_dsum > 5'd9);
            if (w_carry) w_dsum = w_dsum - 5'd10;
            w_score_sum[4*d +: 4] = w_dsum[3:0];
        end
        w_score_nx = w_carry ? c_score_sat : w_score_sum;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= c_st_idle;
            r_frames  <= '0;
            r_fright  <= 1'b0;
            r_fcnt    <= '0;
            r_lives   <= c_lives_ld;
            r_level   <= 4'd1;
            r_score   <= '0;
            r_respawn <= 1'b0;
            r_reload  <= 1'b0;
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync3   <= 1'b0;
        end else begin
            r_sync1   <= frame_clk;
            r_sync2   <= r_sync1;
            r_sync3   <= r_sync2;
            r_state   <= w_next;
            r_lives   <= w_lives_nx;
            r_level   <= w_level_nx;
            r_respawn <= w_respawn_nx;
            r_reload  <= w_reload_nx;

            if (w_next != r_state)
                r_frames <= w_frames_ld;
            else if (w_tick && (r_frames != '0))
                r_frames <= r_frames - c_frame_one;

            if (w_in_play && (w_next == c_st_play)) begin
                if (power_eaten) begin
                    r_fright <= 1'b1;
                    r_fcnt   <= c_fright_ld;
                end else if (r_fright && w_tick) begin
                    if (r_fcnt <= c_fcnt_one) r_fright <= 1'b0;
                    r_fcnt <= (r_fcnt == '0) ? '0 : r_fcnt - c_fcnt_one;
                end
            end else begin
                r_fright <= 1'b0;
                r_fcnt   <= '0;
            end

            if (w_reinit)       r_score <= '0;
            else if (w_in_play) r_score <= w_score_nx;
        end
    end

    assign state         = r_state;
    assign run_en        = w_in_play;
    assign frightened    = r_fright;
    assign respawn       = r_respawn;
    assign pellet_reload = r_reload;
    assign lives         = r_lives;
    assign level         = r_level;
    assign score_bcd     = r_score;
    assign lose_game     = (r_state == c_st_over);
    assign win_game      = (r_state == c_st_win);

endmodule
`default_nettype wire

// File: tb/tb_game_state_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module  : tb_game_state_ctrl
//  Brief   : Directed self-checking bench for game_state_ctrl.
//  Revision: 1.0  initial release
// ============================================================================
module tb_game_state_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic        start;
    logic [3:0]  ghost_hit;
    logic        pellet_eaten;
    logic        power_eaten;
    logic        maze_cleared;
    logic [2:0]  state;
    logic        run_en;
    logic        frightened;
    logic        respawn;
    logic        pellet_reload;
    logic [2:0]  lives;
    logic [3:0]  level;
    logic [19:0] score_bcd;
    logic        lose_game;
    logic        win_game;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    game_state_ctrl dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_clk     (frame_clk),
        .start         (start),
        .ghost_hit     (ghost_hit),
        .pellet_eaten  (pellet_eaten),
        .power_eaten   (power_eaten),
        .maze_cleared  (maze_cleared),
        .state         (state),
        .run_en        (run_en),
        .frightened    (frightened),
        .respawn       (respawn),
        .pellet_reload (pellet_reload),
        .lives         (lives),
        .level         (level),
        .score_bcd     (score_bcd),
        .lose_game     (lose_game),
        .win_game      (win_game)
    );

    always #10 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // One synchronised frame tick; returns just after the edge that consumes it.
    task automatic tick();
        frame_clk = 1'b0;
        step(3);
        frame_clk = 1'b1;
        step(3);
        frame_clk = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ev(input logic pel, input logic pow, input logic [3:0] gh, input logic mz);
        pellet_eaten = pel;
        power_eaten  = pow;
        ghost_hit    = gh;
        maze_cleared = mz;
        step(1);
        pellet_eaten = 1'b0;
        power_eaten  = 1'b0;
        ghost_hit    = 4'd0;
        maze_cleared = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"},  32'(state), 32'd0);
        check({tag, "_lives"},  32'(lives), 32'd3);
        check({tag, "_level"},  32'(level), 32'd1);
        check({tag, "_score"},  32'(score_bcd), 32'h0);
        check({tag, "_run"},    32'(run_en), 32'd0);
        check({tag, "_fright"}, 32'(frightened), 32'd0);
        check({tag, "_resp"},   32'(respawn), 32'd0);
        check({tag, "_reload"}, 32'(pellet_reload), 32'd0);
        check({tag, "_lose"},   32'(lose_game), 32'd0);
        check({tag, "_win"},    32'(win_game), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; start = 1'b0; ghost_hit = 4'd0;
        pellet_eaten = 1'b0; power_eaten = 1'b0; maze_cleared = 1'b0;
        step(3);
        Reset = 1'b0;
        check_reset_vals("rst");
        step(1);
        check("idle_no_start", 32'(state), 32'd0);

        // Start a game
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("start_state", 32'(state), 32'd1);
        check("start_resp", 32'(respawn), 32'd1);
        check("start_reload", 32'(pellet_reload), 32'd1);
        step(1);
        check("resp_one_clk", 32'(respawn), 32'd0);
        check("reload_one_clk", 32'(pellet_reload), 32'd0);
        ev(1'b1, 1'b0, 4'd0, 1'b0);
        check("ready_ignores_pellet", 32'(score_bcd), 32'h0);
        ticks(119);
        check("ready_119", 32'(state), 32'd1);
        check("ready_119_run", 32'(run_en), 32'd0);
        tick();
        check("ready_120", 32'(state), 32'd2);
        check("ready_120_run", 32'(run_en), 32'd1);

        // Scoring and frightened mode
        ev(1'b1, 1'b0, 4'd0, 1'b0);
        ev(1'b1, 1'b0, 4'd0, 1'b0);
        ev(1'b1, 1'b0, 4'd0, 1'b0);
        check("three_pellets", 32'(score_bcd), 32'h30);
        ev(1'b0, 1'b1, 4'd0, 1'b0);
        check("power_score", 32'(score_bcd), 32'h80);
        check("power_fright", 32'(frightened), 32'd1);
        ev(1'b0, 1'b0, 4'b0010, 1'b0);
        check("eat_ghost_score", 32'(score_bcd), 32'h280);
        check("eat_ghost_state", 32'(state), 32'd2);
        ticks(359);
        check("fright_359", 32'(frightened), 32'd1);
        tick();
        check("fright_360", 32'(frightened), 32'd0);

        // First death, with a pellet in the same clock
        ev(1'b1, 1'b0, 4'b1000, 1'b0);
        check("death1_score", 32'(score_bcd), 32'h290);
        check("death1_state", 32'(state), 32'd3);
        check("death1_run", 32'(run_en), 32'd0);
        ticks(89);
        check("dying_89", 32'(state), 32'd3);
        check("dying_89_lives", 32'(lives), 32'd3);
        tick();
        check("death1_ready", 32'(state), 32'd1);
        check("death1_lives", 32'(lives), 32'd2);
        check("death1_resp", 32'(respawn), 32'd1);
        check("death1_noreload", 32'(pellet_reload), 32'd0);

        // Second death coincides with maze_cleared: death wins
        ticks(120);
        ev(1'b0, 1'b0, 4'b0001, 1'b1);
        check("death_wins", 32'(state), 32'd3);
        ticks(90);
        check("death2_lives", 32'(lives), 32'd1);
        check("death2_state", 32'(state), 32'd1);

        // Third death ends the game
        ticks(120);
        ev(1'b0, 1'b0, 4'b0100, 1'b0);
        ticks(90);
        check("over_state", 32'(state), 32'd5);
        check("over_lives", 32'(lives), 32'd0);
        check("over_lose", 32'(lose_game), 32'd1);
        check("over_run", 32'(run_en), 32'd0);
        check("over_score", 32'(score_bcd), 32'h290);
        step(5);
        check("over_hold", 32'(state), 32'd5);

        // Restart, then clear all levels
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("restart_state", 32'(state), 32'd1);
        check("restart_lives", 32'(lives), 32'd3);
        check("restart_score", 32'(score_bcd), 32'h0);
        check("restart_reload", 32'(pellet_reload), 32'd1);
        for (int lv = 1; lv < 4; lv++) begin
            ticks(120);
            ev(1'b0, 1'b0, 4'd0, 1'b1);
            check("clear_state", 32'(state), 32'd4);
            ticks(90);
            check("clear_to_ready", 32'(state), 32'd1);
            check("clear_level", 32'(level), 32'(lv + 1));
            check("clear_reload", 32'(pellet_reload), 32'd1);
            check("clear_resp", 32'(respawn), 32'd1);
        end
        ticks(120);
        ev(1'b0, 1'b0, 4'd0, 1'b1);
        ticks(89);
        check("clear_89", 32'(state), 32'd4);
        tick();
        check("win_state", 32'(state), 32'd6);
        check("win_flag", 32'(win_game), 32'd1);
        check("win_level", 32'(level), 32'd4);
        check("win_noreload", 32'(pellet_reload), 32'd0);
        step(3);
        check("win_hold", 32'(state), 32'd6);

        // Restart from WIN with start held, then reset mid-DYING
        start = 1'b1;
        step(1);
        check("win_restart", 32'(state), 32'd1);
        check("win_restart_level", 32'(level), 32'd1);
        ticks(120);
        check("play_again", 32'(state), 32'd2);
        ev(1'b1, 1'b0, 4'b1000, 1'b0);
        check("death4_state", 32'(state), 32'd3);
        check("death4_score", 32'(score_bcd), 32'h10);
        ticks(50);
        Reset = 1'b1;
        step(1);
        check_reset_vals("midrst");
        Reset = 1'b0;
        step(4);
        check("held_start_idle", 32'(state), 32'd0);
        start = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("fresh_edge", 32'(state), 32'd1);
        ticks(119);
        check("ready2_119", 32'(state), 32'd1);
        tick();
        check("ready2_120", 32'(state), 32'd2);

        // Drive the score to saturation
        ev(1'b0, 1'b1, 4'd0, 1'b0);
        check("sat_power", 32'(score_bcd), 32'h50);
        pellet_eaten = 1'b1;
        power_eaten  = 1'b1;
        ghost_hit    = 4'b1111;
        step(1);
        check("all_ghosts_200", 32'(score_bcd), 32'h310);
        check("all_ghosts_alive", 32'(state), 32'd2);
        step(383);
        pellet_eaten = 1'b0;
        power_eaten  = 1'b0;
        ghost_hit    = 4'd0;
        check("bulk_score", 32'(score_bcd), 32'h99890);
        ev(1'b0, 1'b1, 4'd0, 1'b0);
        ev(1'b0, 1'b1, 4'd0, 1'b0);
        check("preload_99990", 32'(score_bcd), 32'h99990);
        ev(1'b1, 1'b0, 4'd0, 1'b0);
        check("saturate", 32'(score_bcd), 32'h99999);
        ev(1'b1, 1'b0, 4'd0, 1'b0);
        check("saturate_hold", 32'(score_bcd), 32'h99999);
        check("saturate_state", 32'(state), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
